// File: rtl/bnn_layer_sequencer.sv
// Layer-pass controller for a 64-channel BNN datapath: weight load, psum clear,
// activation stream, pipeline drain and result pop, with registered datapath strobes.
module bnn_layer_sequencer #(
    parameter int unsigned WIDTH          = 14,
    parameter int unsigned O_CH           = 64,
    parameter int unsigned OUT_ROW_LENGTH = 4,
    parameter int unsigned DRAIN_CYC      = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [15:0]      cfg_n_act_in,
    input  logic             cfg_keep_w_in,
    input  logic [8:0]       wt_data_in,
    input  logic             wt_valid_in,
    output logic             wt_ready_out,
    input  logic [8:0]       act_data_in,
    input  logic             act_valid_in,
    output logic             act_ready_out,
    output logic [8:0]       dp_data_out,
    output logic             dp_load_weight_out,
    output logic             dp_in_valid_out,
    output logic             dp_pop_out,
    output logic             dp_rst_n_out,
    input  logic [WIDTH-1:0] dp_sum_in,
    output logic [WIDTH-1:0] res_data_out,
    output logic [7:0]       res_index_out,
    output logic             res_valid_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DATA_W  = 9;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned POP_LEN = O_CH * OUT_ROW_LENGTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_POP,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CNT_W-1:0]   n_act_q;
    logic               start_acc;
    logic               wt_acc;
    logic               act_acc;
    logic               underrun;
    logic [DATA_W-1:0]  dp_data_d;

    // Next-state and per-cycle handshake decode; cnt is the per-state beat/cycle counter.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        start_acc = 1'b0;
        wt_acc    = 1'b0;
        act_acc   = 1'b0;
        underrun  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in) begin
                    start_acc = 1'b1;
                    cnt_d     = '0;
                    state_d   = cfg_keep_w_in ? S_CLR : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (wt_valid_in && wt_ready_out) begin
                    wt_acc = 1'b1;
                    cnt_d  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(O_CH - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CLR;
                    end
                end else if (cnt != '0) begin
                    // A gap after the first word would desync the datapath's weight index.
                    underrun = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = (n_act_q == '0) ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                if (act_valid_in && act_ready_out) begin
                    act_acc = 1'b1;
                    cnt_d   = cnt + CNT_W'(1);
                    if (cnt == n_act_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(POP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dp_data_d = '0;
        if (wt_acc) begin
            dp_data_d = wt_data_in;
        end else if (act_acc) begin
            dp_data_d = act_data_in;
        end
    end

    // State, config and all registered outputs; state-aligned strobes are decoded from state_d.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= S_IDLE;
            cnt                <= '0;
            n_act_q            <= '0;
            wt_ready_out       <= 1'b0;
            act_ready_out      <= 1'b0;
            dp_data_out        <= '0;
            dp_load_weight_out <= 1'b0;
            dp_in_valid_out    <= 1'b0;
            dp_pop_out         <= 1'b0;
            dp_rst_n_out       <= 1'b0;
            res_data_out       <= '0;
            res_index_out      <= '0;
            res_valid_out      <= 1'b0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            err_out            <= 1'b0;
        end else begin
            state              <= state_d;
            cnt                <= cnt_d;
            if (start_acc) begin
                n_act_q <= cfg_n_act_in;
            end
            wt_ready_out       <= (state_d == S_LOAD_W);
            act_ready_out      <= (state_d == S_STREAM);
            dp_data_out        <= dp_data_d;
            dp_load_weight_out <= wt_acc;
            dp_in_valid_out    <= act_acc;
            dp_pop_out         <= (state_d == S_POP);
            dp_rst_n_out       <= (state_d != S_CLR);
            res_valid_out      <= (state == S_POP);
            res_data_out       <= (state == S_POP) ? dp_sum_in : '0;
            res_index_out      <= (state == S_POP) ? IDX_W'(cnt) : '0;
            busy_out           <= (state_d != S_IDLE);
            done_out           <= (state_d == S_DONE);
            if (start_acc) begin
                err_out <= 1'b0;
            end else if (underrun) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Randomized bench for bnn_layer_sequencer: drives weight/activation streams, emulates
// the datapath sum output, and checks each pass against an expected-transaction model.
module tb_bnn_layer_sequencer;

    localparam int unsigned WIDTH     = 14;
    localparam int unsigned O_CH      = 64;
    localparam int unsigned POP_LEN   = 256;
    localparam int unsigned DRAIN_CYC = 64;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              start_in;
    logic [15:0]       cfg_n_act_in;
    logic              cfg_keep_w_in;
    logic [8:0]        wt_data_in;
    logic              wt_valid_in;
    logic              wt_ready_out;
    logic [8:0]        act_data_in;
    logic              act_valid_in;
    logic              act_ready_out;
    logic [8:0]        dp_data_out;
    logic              dp_load_weight_out;
    logic              dp_in_valid_out;
    logic              dp_pop_out;
    logic              dp_rst_n_out;
    logic [WIDTH-1:0]  dp_sum_in;
    logic [WIDTH-1:0]  res_data_out;
    logic [7:0]        res_index_out;
    logic              res_valid_out;
    logic              busy_out;
    logic              done_out;
    logic              err_out;

    logic [WIDTH-1:0]  sum_tab [POP_LEN];
    logic [8:0]        pop_idx;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;

    bnn_layer_sequencer dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .cfg_n_act_in       (cfg_n_act_in),
        .cfg_keep_w_in      (cfg_keep_w_in),
        .wt_data_in         (wt_data_in),
        .wt_valid_in        (wt_valid_in),
        .wt_ready_out       (wt_ready_out),
        .act_data_in        (act_data_in),
        .act_valid_in       (act_valid_in),
        .act_ready_out      (act_ready_out),
        .dp_data_out        (dp_data_out),
        .dp_load_weight_out (dp_load_weight_out),
        .dp_in_valid_out    (dp_in_valid_out),
        .dp_pop_out         (dp_pop_out),
        .dp_rst_n_out       (dp_rst_n_out),
        .dp_sum_in          (dp_sum_in),
        .res_data_out       (res_data_out),
        .res_index_out      (res_index_out),
        .res_valid_out      (res_valid_out),
        .busy_out           (busy_out),
        .done_out           (done_out),
        .err_out            (err_out)
    );

    always #5 clk_in = ~clk_in;

    // Datapath stand-in: pop k presents sum_tab[k]; its index restarts on every psum clear.
    always @(posedge clk_in) begin
        if (!dp_rst_n_out) pop_idx <= '0;
        else if (dp_pop_out) pop_idx <= pop_idx + 9'd1;
    end
    assign dp_sum_in = dp_pop_out ? sum_tab[pop_idx[7:0]] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    // One full pass; expectations come from the words the bench itself handed over.
    task automatic run_pass(input bit keep_w, input int n_act, input bit [15:0] pat,
                            input int pat_len, input bit poke_start, input int wt_delay,
                            input bit incr_w);
        logic [8:0] wts [O_CH];
        logic [8:0] acts [$];
        int hs_cyc [$];
        int n_wsent = 0, n_asent = 0, wait_cnt = 0, pi = 0;
        int n_load = 0, first_load = -1, last_load = -1, werr = 0;
        int n_clr = 0, clr_c = -1, n_iv = 0, last_iv = -1, aerr = 0, stray = 0;
        int n_pop = 0, first_pop = -1, last_pop = -1;
        int n_res = 0, last_res = -1, rerr = 0, n_done = 0, done_c = -1;
        int start_c;
        bit poked = 0;
        bit v;
        for (int i = 0; i < O_CH; i++) wts[i] = incr_w ? 9'(i) : 9'($urandom);
        for (int i = 0; i < n_act; i++) acts.push_back(9'($urandom));

        start_in = 1'b1; cfg_n_act_in = 16'(n_act); cfg_keep_w_in = keep_w;
        start_c = cyc;
        tick();
        start_in = 1'b0; cfg_n_act_in = 16'($urandom); cfg_keep_w_in = 1'($urandom);
        check("err_cleared_on_start", err_out, 0);
        check("busy_after_start", busy_out, 1);

        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            if (dp_load_weight_out) begin
                if (n_load >= O_CH || dp_data_out !== wts[n_load]) werr++;
                if (first_load < 0) first_load = cyc;
                last_load = cyc;
                n_load++;
            end
            if (!dp_rst_n_out) begin n_clr++; clr_c = cyc; end
            if (dp_in_valid_out) begin
                if (n_iv >= n_act || dp_data_out !== acts[n_iv] || cyc != hs_cyc[n_iv] + 1) aerr++;
                last_iv = cyc;
                n_iv++;
            end
            if (!dp_load_weight_out && !dp_in_valid_out && dp_data_out != 0) stray++;
            if (dp_pop_out) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            if (res_valid_out) begin
                if (n_res >= POP_LEN || res_index_out !== 8'(n_res) ||
                    res_data_out !== sum_tab[n_res]) rerr++;
                last_res = cyc;
                n_res++;
            end
            if (done_out) begin n_done++; done_c = cyc; end

            if (wt_ready_out && n_wsent < O_CH && (n_wsent > 0 || wait_cnt >= wt_delay)) begin
                wt_valid_in = 1'b1; wt_data_in = wts[n_wsent]; n_wsent++;
            end else begin
                wt_valid_in = 1'b0; wt_data_in = 9'($urandom);
            end
            if (wt_ready_out) wait_cnt++;
            v = 1'b0;
            if (act_ready_out && n_asent < n_act) begin
                v = (pat_len > 0) ? pat[pi % pat_len] : ($urandom_range(99) < 70);
                pi++;
            end
            act_valid_in = v;
            act_data_in  = v ? acts[n_asent] : 9'($urandom);
            if (v) begin hs_cyc.push_back(cyc); n_asent++; end
            if (poke_start && !poked && n_clr > 0 && cyc == clr_c + 2) begin
                start_in = 1'b1; cfg_n_act_in = 16'd7; cfg_keep_w_in = 1'b0; poked = 1;
            end else begin
                start_in = 1'b0;
            end
            tick();
        end
        wt_valid_in = 1'b0; act_valid_in = 1'b0; start_in = 1'b0;

        check("wt_load_count", n_load, keep_w ? 0 : O_CH);
        check("wt_data_order", werr, 0);
        if (!keep_w) begin
            check("wt_load_contiguous", last_load - first_load + 1, O_CH);
            check("clr_after_last_wt", clr_c, last_load);
        end else begin
            check("clr_follows_start", clr_c, start_c + 1);
        end
        check("clr_pulse_count", n_clr, 1);
        check("act_beats", n_iv, n_act);
        check("act_data_timing", aerr, 0);
        check("stray_dp_data", stray, 0);
        check("drain_gap", first_pop - (n_act > 0 ? last_iv : clr_c),
              n_act > 0 ? DRAIN_CYC : DRAIN_CYC + 1);
        check("pop_count", n_pop, POP_LEN);
        check("pop_contiguous", last_pop - first_pop + 1, POP_LEN);
        check("res_count", n_res, POP_LEN);
        check("res_index_data", rerr, 0);
        check("res_follows_pop", last_res, last_pop + 1);
        check("done_once", n_done, 1);
        check("done_with_last_res", done_c, last_res);
        check("idle_after_done", busy_out, 0);
        check("no_err_after_pass", err_out, 0);
    endtask

    initial begin
        int n, cnt_res, cnt_done, cnt_low;
        rst_in = 1'b1; start_in = 1'b0; cfg_n_act_in = '0; cfg_keep_w_in = 1'b0;
        wt_data_in = '0; wt_valid_in = 1'b0; act_data_in = '0; act_valid_in = 1'b0;
        for (int i = 0; i < POP_LEN; i++) sum_tab[i] = WIDTH'($urandom);
        repeat (3) tick();
        check("rst_dp_rst_n", dp_rst_n_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_load", dp_load_weight_out, 0);
        check("rst_pop", dp_pop_out, 0);
        check("rst_res_valid", res_valid_out, 0);
        check("rst_done_err", {done_out, err_out}, 0);
        check("rst_ready", {wt_ready_out, act_ready_out}, 0);
        check("rst_dp_data", dp_data_out, 0);
        rst_in = 1'b0;
        tick();
        check("post_rst_dp_rst_n", dp_rst_n_out, 1);

        run_pass(1'b0, 8, '0, 0, 1'b0, 0, 1'b1);
        run_pass(1'b1, 4, '0, 0, 1'b0, 0, 1'b0);
        run_pass(1'b1, 4, 16'b1011001, 7, 1'b0, 0, 1'b0);

        // Weight underrun after word 10.
        start_in = 1'b1; cfg_keep_w_in = 1'b0; cfg_n_act_in = 16'd3;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 20 && !wt_ready_out; i++) tick();
        for (int i = 0; i <= 10; i++) begin
            wt_valid_in = 1'b1; wt_data_in = 9'(i + 100);
            tick();
        end
        wt_valid_in = 1'b0;
        check("uf_last_word_load", dp_load_weight_out, 1);
        check("uf_last_word_data", dp_data_out, 110);
        tick();
        check("uf_load_dropped", dp_load_weight_out, 0);
        check("uf_err_set", err_out, 1);
        check("uf_idle", busy_out, 0);
        check("uf_ready_low", wt_ready_out, 0);
        cnt_done = 0; cnt_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_out) cnt_done++;
            if (!dp_rst_n_out) cnt_low++;
            tick();
        end
        check("uf_no_done", cnt_done, 0);
        check("uf_no_clear", cnt_low, 0);
        check("uf_err_sticky", err_out, 1);

        run_pass(1'b0, 12, '0, 0, 1'b0, 5, 1'b0);

        // Reset while popping index 100.
        start_in = 1'b1; cfg_keep_w_in = 1'b1; cfg_n_act_in = 16'd0;
        tick();
        start_in = 1'b0;
        n = 0;
        for (int i = 0; i < 600 && n < 101; i++) begin
            if (dp_pop_out) n++;
            if (n < 101) tick();
        end
        check("rp_reach_pop100", n, 101);
        check("rp_prev_res_index", res_index_out, 99);
        rst_in = 1'b1;
        tick();
        check("rp_pop_low", dp_pop_out, 0);
        check("rp_strobes_low", {dp_load_weight_out, dp_in_valid_out}, 0);
        check("rp_dp_rst_n_low", dp_rst_n_out, 0);
        check("rp_busy_low", busy_out, 0);
        check("rp_res_valid_low", res_valid_out, 0);
        rst_in = 1'b0;
        cnt_res = 0; cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid_out) cnt_res++;
            if (done_out || busy_out) cnt_done++;
        end
        check("rp_no_more_res", cnt_res, 0);
        check("rp_stays_idle", cnt_done, 0);

        run_pass(1'b1, 0, '0, 0, 1'b1, 0, 1'b0);
        run_pass(1'b0, 5, '0, 0, 1'b1, 2, 1'b0);
        for (int k = 0; k < 3; k++)
            run_pass(1'($urandom), $urandom_range(20), '0, 0, 1'b0, $urandom_range(4), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_layer_sequencer.md
Name: bnn_layer_sequencer

Overview:
- Controller that sequences one 64-output-channel BNN datapath (weight-stationary PE column with rotating psum rows) through one layer pass: weight load → psum clear → activation stream → pipeline drain → result pop.
- Converts ready/valid weight and activation streams and a start pulse into the datapath's contiguous load_weight/in_valid/pop strobes and its active-low psum clear.
- Forwards popped sums as a valid-only result stream.

Parameters:
- WIDTH, 14, psum/result width
- O_CH, 64, output channels = weight-load burst length
- OUT_ROW_LENGTH, 4, psums per channel row; pop burst = O_CH*OUT_ROW_LENGTH
- DRAIN_CYC, 64, cycles waited after the last activation before popping (≥ O_CH-1 + PE latency)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous reset, active-high
- start_in  input  1  one-cycle start pulse; ignored unless IDLE
- cfg_n_act_in  input  16  activations in this pass; latched on accepted start
- cfg_keep_w_in  input  1  1 = skip LOAD_W and reuse resident weights; latched on start
- wt_data_in  input  9  weight word
- wt_valid_in  input  1  weight valid
- wt_ready_out  output  1  weight ready
- act_data_in  input  9  activation word
- act_valid_in  input  1  activation valid
- act_ready_out  output  1  activation ready
- dp_data_out  output  9  datapath data_in
- dp_load_weight_out  output  1  datapath load_weight_in
- dp_in_valid_out  output  1  datapath in_valid_in
- dp_pop_out  output  1  datapath pop_in
- dp_rst_n_out  output  1  datapath rst_in (active-low clear)
- dp_sum_in  input  WIDTH  datapath sum_out
- res_data_out  output  WIDTH  popped sum
- res_index_out  output  8  pop index 0..255
- res_valid_out  output  1  result valid (no backpressure)
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  one-cycle pulse on pass completion
- err_out  output  1  sticky weight-underrun flag; cleared on next accepted start

Behaviour:
- Reset: state IDLE; all dp_* strobes and res_valid_out/busy_out/done_out/err_out = 0; dp_data_out = 0; dp_rst_n_out = 0 while rst_in=1. Reset mid-pass aborts immediately; no result is emitted.
- All dp_* and res_* outputs are registered. A handshake in cycle t appears at the datapath in cycle t+1.
- IDLE: on start_in, latch config and clear err_out. Next state is LOAD_W, or CLR if cfg_keep_w_in=1.
- LOAD_W:
  - Enter only once wt_valid_in=1; wt_ready_out=1 for exactly O_CH accepted words.
  - dp_load_weight_out is contiguous for O_CH cycles; dp_data_out carries words in order. The datapath indexes by a counter that resets when the strobe drops, so gaps are illegal.
  - wt_valid_in=0 after the first word: abort, deassert strobe, set err_out, go to IDLE, no done_out.
- CLR: dp_rst_n_out=0 for exactly 1 cycle, then go to STREAM.
- STREAM:
  - act_ready_out=1; each act_valid_in beat produces dp_in_valid_out=1 with dp_data_out=act_data_in. Gaps are allowed (dp_in_valid_out=0, dp_data_out=0).
  - Exit after cfg_n_act beats. n_act=0 goes straight to DRAIN.
- DRAIN: count DRAIN_CYC cycles, all strobes low, then go to POP.
- POP:
  - dp_pop_out high for exactly O_CH*OUT_ROW_LENGTH (256) contiguous cycles; 9-bit counter.
  - In each pop cycle k, dp_sum_in holds index k. Register it to res_data_out with res_index_out=k and res_valid_out=1 in the next cycle.
  - After the last pop, go to DONE.
- DONE: done_out=1 for one cycle (coincides with the final res_valid_out); next state IDLE.
- wt_ready_out/act_ready_out are 0 outside LOAD_W/STREAM. start_in while busy is ignored.

Test Plan:
- Full pass: start, n_act=8, weights 0..63 → dp_load high 64 cycles with words 0..63; one dp_rst_n low pulse; 8 dp_in_valid; 64 drain cycles; 256 results with index 0..255; done_out once.
- cfg_keep_w_in=1, n_act=4 → no LOAD_W; CLR follows start by 1 cycle; 4 valids; 256 results.
- Activation gaps: act_valid pattern 1,0,0,1,1,0,1 with n_act=4 → dp_in_valid mirrors it one cycle later; STREAM exits after the 4th beat.
- Weight underrun: wt_valid drops after word 10 → dp_load low next cycle; err_out=1; state IDLE; no done_out; next start clears err_out.
- rst_in=1 during POP at index 100 → next cycle all strobes 0, dp_rst_n_out=0, busy_out=0; no further res_valid_out.
- start_in pulsed during STREAM and n_act=0 → start ignored; the n_act=0 pass goes CLR→DRAIN→POP and still yields 256 results.
